// File: rtl/ifft_butterfly_pipe_pkg.sv
// Shared constants and twiddle index encoding for the inverse radix-2 butterfly.
package ifft_butterfly_pipe_pkg;

    localparam int INV_SQRT2_Q8 = 181;
    localparam int Q8_SHIFT     = 8;

    typedef enum logic [1:0] {
        TW_0 = 2'd0,
        TW_1 = 2'd1,
        TW_2 = 2'd2,
        TW_3 = 2'd3
    } tw_idx_e;

endpackage

// File: rtl/ifft_butterfly_pipe_if.sv
// Stream bundle for one butterfly: input pair handshake, output pair handshake, overflow.
interface ifft_butterfly_pipe_if #(
    parameter int N = 3
);
    localparam int W = 2 ** N;

    logic         in_valid;
    logic         in_ready;
    logic [1:0]   k;
    logic [W-1:0] in_1_r, in_1_i, in_2_r, in_2_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_1_r, out_1_i, out_2_r, out_2_i;
    logic         ovf;
    logic         clr_ovf;

    modport slave (
        input  in_valid, k, in_1_r, in_1_i, in_2_r, in_2_i, out_ready, clr_ovf,
        output in_ready, out_valid, out_1_r, out_1_i, out_2_r, out_2_i, ovf
    );

    modport master (
        output in_valid, k, in_1_r, in_1_i, in_2_r, in_2_i, out_ready, clr_ovf,
        input  in_ready, out_valid, out_1_r, out_1_i, out_2_r, out_2_i, ovf
    );

endinterface

// File: rtl/ifft_butterfly_pipe_twiddle_mul.sv
// Combinational multiply by the conjugate twiddle W8^-k, wrapped to W bits with overflow flag.
module ifft_twiddle_mul
    import ifft_butterfly_pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] r,
    input  logic [W-1:0] i,
    input  logic [1:0]   k,
    output logic [W-1:0] tr,
    output logic [W-1:0] ti,
    output logic         ovf
);
    localparam int WE = W + 10;

    logic signed [W:0]    r_x, i_x, diff, sum, nsum;
    logic signed [WE-1:0] fr, fi;

    // x * 181 >>> 8 at W+10 bits, floor rounding via arithmetic shift
    function automatic logic signed [WE-1:0] mul_isq(input logic signed [W:0] x);
        logic signed [WE-1:0] p;
        p = WE'(x) * WE'(INV_SQRT2_Q8);
        return p >>> Q8_SHIFT;
    endfunction

    assign r_x  = $signed({r[W-1], r});
    assign i_x  = $signed({i[W-1], i});
    assign diff = r_x - i_x;
    assign sum  = r_x + i_x;
    assign nsum = -r_x - i_x;

    always_comb begin
        fr = '0;
        fi = '0;
        unique case (tw_idx_e'(k))
            TW_0: begin fr = WE'(r_x);       fi = WE'(i_x);    end
            TW_1: begin fr = mul_isq(diff);  fi = mul_isq(sum); end
            TW_2: begin fr = -WE'(i_x);      fi = WE'(r_x);    end
            TW_3: begin fr = mul_isq(nsum);  fi = mul_isq(diff); end
        endcase
    end

    assign tr  = fr[W-1:0];
    assign ti  = fi[W-1:0];
    assign ovf = (fr != WE'($signed(tr))) || (fi != WE'($signed(ti)));

endmodule

// File: rtl/ifft_butterfly_pipe.sv
// Two-stage streaming inverse radix-2 butterfly with global stall, optional /2 scaling, sticky overflow.
module ifft_butterfly_pipe
    import ifft_butterfly_pipe_pkg::*;
#(
    parameter int N     = 3,
    parameter int SCALE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ifft_butterfly_pipe_if.slave bus
);
    localparam int W = 2 ** N;

    logic         en;
    logic         v1, out_valid, ovf;
    logic [W-1:0] a_r, a_i, t_r, t_i;
    logic [W-1:0] o1_r, o1_i, o2_r, o2_i;
    logic [W-1:0] tw_r, tw_i;
    logic         tw_ovf;
    logic signed [W:0] s1_r, s1_i, s2_r, s2_i;
    logic         ovf_s1, ovf_s2;

    function automatic logic [W-1:0] fit(input logic signed [W:0] s);
        if (SCALE != 0) return s[W:1];
        else            return s[W-1:0];
    endfunction

    function automatic logic wraps(input logic signed [W:0] s);
        return (SCALE == 0) && (s[W] != s[W-1]);
    endfunction

    ifft_twiddle_mul #(.W(W)) u_tw (
        .r   (bus.in_2_r),
        .i   (bus.in_2_i),
        .k   (bus.k),
        .tr  (tw_r),
        .ti  (tw_i),
        .ovf (tw_ovf)
    );

    assign en = !out_valid || bus.out_ready;

    assign s1_r = $signed({a_r[W-1], a_r}) + $signed({t_r[W-1], t_r});
    assign s1_i = $signed({a_i[W-1], a_i}) + $signed({t_i[W-1], t_i});
    assign s2_r = $signed({a_r[W-1], a_r}) - $signed({t_r[W-1], t_r});
    assign s2_i = $signed({a_i[W-1], a_i}) - $signed({t_i[W-1], t_i});

    // Overflow only counts on loads that carry a valid pair
    assign ovf_s1 = en && bus.in_valid && tw_ovf;
    assign ovf_s2 = en && v1 && (wraps(s1_r) || wraps(s1_i) || wraps(s2_r) || wraps(s2_i));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            a_r  <= '0;  a_i  <= '0;  t_r  <= '0;  t_i  <= '0;
            o1_r <= '0;  o1_i <= '0;  o2_r <= '0;  o2_i <= '0;
        end else begin
            if (en) begin
                v1        <= bus.in_valid;
                a_r       <= bus.in_1_r;
                a_i       <= bus.in_1_i;
                t_r       <= tw_r;
                t_i       <= tw_i;
                out_valid <= v1;
                o1_r      <= fit(s1_r);
                o1_i      <= fit(s1_i);
                o2_r      <= fit(s2_r);
                o2_i      <= fit(s2_i);
            end
            if (ovf_s1 || ovf_s2) ovf <= 1'b1;
            else if (bus.clr_ovf) ovf <= 1'b0;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid;
    assign bus.out_1_r   = o1_r;
    assign bus.out_1_i   = o1_i;
    assign bus.out_2_r   = o2_r;
    assign bus.out_2_i   = o2_i;
    assign bus.ovf       = ovf;

endmodule
